// File: rtl/rv_hazard_unit_pkg.sv
// Shared constants, select/trace types and helpers for the FlexRV32 hazard/control unit.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package rv_hazard_unit_pkg;

    localparam logic [4:0] REG_X0         = 5'd0;
    localparam int         NUM_REGS       = 32;
    localparam int         BP_STAGES_DFLT = 3;

    // Width of an operand select: value 0 = register file, k+1 = forward from source k.
    function automatic int sel_width(input int n_src);
        return $clog2(n_src + 1);
    endfunction

    // Operand select for the default three-source forwarding network.
    typedef logic [$clog2(BP_STAGES_DFLT + 1)-1:0] bp_sel_t;

    // Dominant reason decode is held, exported for the debug trace.
    typedef enum logic [2:0] {
        HZ_NONE         = 3'd0,
        HZ_FLUSH        = 3'd1,
        HZ_BACKPRESSURE = 3'd2,
        HZ_ALU_DATA     = 3'd3,
        HZ_SCOREBOARD   = 3'd4,
        HZ_PAUSE        = 3'd5
    } hz_cause_t;

endpackage

// File: rtl/rv_hazard_unit_if.sv
// Pipeline <-> hazard unit signal bundle: forwarding sources, scoreboard traffic, stall/flush controls.
// Latency: none (wiring only).
// Backpressure: i_alu2_ready carries alu2 back-pressure into the unit.
interface rv_hazard_unit_if
    import rv_hazard_unit_pkg::*;
#(
    parameter int BP_STAGES = 3
) ();
    localparam int SELW = sel_width(BP_STAGES);

    logic                   i_pc_change;
    logic                   i_need_pause;
    logic                   i_alu2_ready;
    logic                   i_decode_inst_sup;
    logic [4:0]             i_decode_rs1;
    logic [4:0]             i_decode_rs2;
    logic [4:0]             i_alu_rs1;
    logic [4:0]             i_alu_rs2;
    logic [5*BP_STAGES-1:0] i_bp_rd;
    logic [BP_STAGES-1:0]   i_bp_we;
    logic [BP_STAGES-1:0]   i_bp_rdy;
    logic                   i_lng_issue;
    logic [4:0]             i_lng_rd;
    logic                   i_lng_done;
    logic [4:0]             i_lng_done_rd;

    logic                   o_fetch_stall;
    logic                   o_decode_stall;
    logic                   o_decode_flush;
    logic                   o_alu1_stall;
    logic                   o_alu1_flush;
    logic                   o_alu2_flush;
    logic [SELW-1:0]        o_rs1_sel;
    logic [SELW-1:0]        o_rs2_sel;
    logic                   o_inv_inst;
    logic                   o_sb_busy;
    hz_cause_t              o_hz_cause;

    modport slave (
        input  i_pc_change, i_need_pause, i_alu2_ready, i_decode_inst_sup,
               i_decode_rs1, i_decode_rs2, i_alu_rs1, i_alu_rs2,
               i_bp_rd, i_bp_we, i_bp_rdy,
               i_lng_issue, i_lng_rd, i_lng_done, i_lng_done_rd,
        output o_fetch_stall, o_decode_stall, o_decode_flush, o_alu1_stall,
               o_alu1_flush, o_alu2_flush, o_rs1_sel, o_rs2_sel,
               o_inv_inst, o_sb_busy, o_hz_cause
    );

    modport master (
        output i_pc_change, i_need_pause, i_alu2_ready, i_decode_inst_sup,
               i_decode_rs1, i_decode_rs2, i_alu_rs1, i_alu_rs2,
               i_bp_rd, i_bp_we, i_bp_rdy,
               i_lng_issue, i_lng_rd, i_lng_done, i_lng_done_rd,
        input  o_fetch_stall, o_decode_stall, o_decode_flush, o_alu1_stall,
               o_alu1_flush, o_alu2_flush, o_rs1_sel, o_rs2_sel,
               o_inv_inst, o_sb_busy, o_hz_cause
    );

endinterface

// File: rtl/rv_hazard_unit_bp_match.sv
// Picks the youngest forwarding source writing a given source register; flags it if its value is not ready yet.
// Latency: combinational.
// Backpressure: none; hit_not_ready is the hazard indication consumed by the stall logic.
module rv_bp_match
    import rv_hazard_unit_pkg::*;
#(
    parameter int  BP_STAGES = 3,
    localparam int SELW      = sel_width(BP_STAGES)
) (
    input  logic [4:0]             rs,
    input  logic [5*BP_STAGES-1:0] bp_rd,
    input  logic [BP_STAGES-1:0]   bp_we,
    input  logic [BP_STAGES-1:0]   bp_rdy,
    output logic [SELW-1:0]        sel,
    output logic                   hit_not_ready
);

    // Scan oldest to youngest so the youngest matching source overwrites older ones;
    // an older ready copy is deliberately ignored once a younger stage claims the register.
    always_comb begin
        sel           = '0;
        hit_not_ready = 1'b0;
        for (int k = BP_STAGES - 1; k >= 0; k--) begin
            if (bp_we[k] && (bp_rd[5*k +: 5] != REG_X0) && (bp_rd[5*k +: 5] == rs)) begin
                sel           = SELW'(k + 1);
                hit_not_ready = !bp_rdy[k];
            end
        end
    end

endmodule

// File: rtl/rv_hazard_unit.sv
// FlexRV32 hazard/control unit: forwarding selects, load-use/scoreboard stalls, redirect flush, delayed invalid-inst flag.
// Latency: stall/flush/select outputs combinational; scoreboard and o_inv_inst state updates take one cycle.
// Backpressure: !i_alu2_ready stalls alu1 and everything upstream of it; flushes override stalls.
module rv_hazard_unit
    import rv_hazard_unit_pkg::*;
#(
    parameter int BP_STAGES    = 3,
    parameter int FLUSH_CYCLES = 1,
    parameter int INV_DEPTH    = 2
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    rv_hazard_unit_if.slave   hz
);

    localparam int SELW = sel_width(BP_STAGES);
    // Counter only needs to hold FLUSH_CYCLES-1; keep at least one bit so FLUSH_CYCLES=1 still elaborates.
    localparam int              CNTW         = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNTW-1:0] FLUSH_RELOAD = CNTW'(FLUSH_CYCLES - 1);

    logic [CNTW-1:0]      flush_cnt;
    logic [NUM_REGS-1:0]  pending;
    logic [NUM_REGS-1:0]  sb_set;
    logic [NUM_REGS-1:0]  sb_clr;
    logic [INV_DEPTH-1:0] inv_pipe;

    logic [SELW-1:0] rs1_sel;
    logic [SELW-1:0] rs2_sel;
    logic            rs1_not_ready;
    logic            rs2_not_ready;

    logic flush_act;
    logic alu_hz;
    logic sb_hz;
    logic alu1_stall;
    logic decode_stall;

    rv_bp_match #(.BP_STAGES(BP_STAGES)) u_match_rs1 (
        .rs            (hz.i_alu_rs1),
        .bp_rd         (hz.i_bp_rd),
        .bp_we         (hz.i_bp_we),
        .bp_rdy        (hz.i_bp_rdy),
        .sel           (rs1_sel),
        .hit_not_ready (rs1_not_ready)
    );

    rv_bp_match #(.BP_STAGES(BP_STAGES)) u_match_rs2 (
        .rs            (hz.i_alu_rs2),
        .bp_rd         (hz.i_bp_rd),
        .bp_we         (hz.i_bp_we),
        .bp_rdy        (hz.i_bp_rdy),
        .sel           (rs2_sel),
        .hit_not_ready (rs2_not_ready)
    );

    // Hazard sources and the stall chain; reset itself counts as a flush so the pipe comes up empty.
    always_comb begin
        flush_act    = !i_reset_n || hz.i_pc_change || (flush_cnt != '0);
        alu_hz       = rs1_not_ready || rs2_not_ready;
        sb_hz        = pending[hz.i_decode_rs1] || pending[hz.i_decode_rs2];
        alu1_stall   = !hz.i_alu2_ready || alu_hz;
        decode_stall = flush_act || hz.i_need_pause || sb_hz || alu1_stall;
    end

    assign hz.o_fetch_stall  = decode_stall;
    assign hz.o_decode_stall = decode_stall;
    assign hz.o_decode_flush = flush_act;
    assign hz.o_alu1_stall   = alu1_stall;
    // A bubble enters alu1 when decode is held but alu1 itself is free to advance.
    assign hz.o_alu1_flush   = flush_act || (decode_stall && !alu1_stall);
    // alu2 gets a bubble while alu1 waits for a forwarded value, unless alu2 is itself held.
    assign hz.o_alu2_flush   = flush_act || (alu_hz && hz.i_alu2_ready);
    assign hz.o_rs1_sel      = rs1_sel;
    assign hz.o_rs2_sel      = rs2_sel;
    assign hz.o_inv_inst     = !inv_pipe[INV_DEPTH-1];
    assign hz.o_sb_busy      = |pending;

    // Debug trace: report the highest-priority reason decode is not advancing.
    always_comb begin
        hz.o_hz_cause = HZ_NONE;
        if (flush_act) begin
            hz.o_hz_cause = HZ_FLUSH;
        end else if (!hz.i_alu2_ready) begin
            hz.o_hz_cause = HZ_BACKPRESSURE;
        end else if (alu_hz) begin
            hz.o_hz_cause = HZ_ALU_DATA;
        end else if (sb_hz) begin
            hz.o_hz_cause = HZ_SCOREBOARD;
        end else if (hz.i_need_pause) begin
            hz.o_hz_cause = HZ_PAUSE;
        end
    end

    // Scoreboard edits this cycle: an op only becomes pending if decode actually issues it.
    always_comb begin
        sb_set = '0;
        sb_clr = '0;
        if (hz.i_lng_issue && !decode_stall && (hz.i_lng_rd != REG_X0)) begin
            sb_set[hz.i_lng_rd] = 1'b1;
        end
        if (hz.i_lng_done) begin
            sb_clr[hz.i_lng_done_rd] = 1'b1;
        end
    end

    // Pending long-latency destinations; a redirect does not cancel ops already in flight, and set beats clear.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~sb_clr) | sb_set;
        end
    end

    // Stretch each redirect to FLUSH_CYCLES cycles; a fresh redirect restarts the window.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            flush_cnt <= '0;
        end else if (hz.i_pc_change) begin
            flush_cnt <= FLUSH_RELOAD;
        end else if (flush_cnt != '0) begin
            flush_cnt <= flush_cnt - 1'b1;
        end
    end

    // Carry the "supported" bit down to the check stage; bubbles are all-supported, stalls hold the pipe.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            inv_pipe <= '1;
        end else if (flush_act) begin
            inv_pipe <= '1;
        end else if (!decode_stall) begin
            inv_pipe[0] <= hz.i_decode_inst_sup;
            for (int i = 1; i < INV_DEPTH; i++) begin
                inv_pipe[i] <= inv_pipe[i-1];
            end
        end
    end

endmodule

// File: tb/tb_rv_hazard_unit.sv
module tb_rv_hazard_unit;
    import rv_hazard_unit_pkg::*;

    localparam int BPS  = 3;
    localparam int FLC  = 3;
    localparam int INVD = 2;

    logic i_clk = 1'b0;
    logic i_reset_n;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    rv_hazard_unit_if #(.BP_STAGES(BPS)) hz ();

    rv_hazard_unit #(
        .BP_STAGES    (BPS),
        .FLUSH_CYCLES (FLC),
        .INV_DEPTH    (INVD)
    ) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .hz        (hz)
    );

    always #5 i_clk = ~i_clk;

    // ---------------- reference model ----------------
    int cyc       = 0;   // index of the current clock cycle
    int flush_end = 0;   // redirect flush visible while cyc < flush_end
    bit sb [32];         // registers owed by an in-flight long-latency op
    bit hist [$];        // supported-bits of instructions that left decode, newest first

    int e_sel1, e_sel2;
    bit e_flush, e_alu_hz, e_sb_hz, e_a1s, e_ds, e_a1f, e_a2f, e_inv, e_busy;

    function automatic int winner(input logic [4:0] rs);
        for (int k = 0; k < BPS; k++) begin
            if (hz.i_bp_we[k] && hz.i_bp_rd[5*k +: 5] != 5'd0 && hz.i_bp_rd[5*k +: 5] == rs)
                return k;
        end
        return -1;
    endfunction

    task automatic model_eval();
        int w1, w2;
        w1 = winner(hz.i_alu_rs1);
        w2 = winner(hz.i_alu_rs2);
        e_sel1   = w1 + 1;
        e_sel2   = w2 + 1;
        e_alu_hz = (w1 >= 0 && !hz.i_bp_rdy[w1]) || (w2 >= 0 && !hz.i_bp_rdy[w2]);
        e_sb_hz  = sb[hz.i_decode_rs1] || sb[hz.i_decode_rs2];
        e_flush  = !i_reset_n || hz.i_pc_change || (cyc < flush_end);
        e_a1s    = !hz.i_alu2_ready || e_alu_hz;
        e_ds     = e_flush || hz.i_need_pause || e_sb_hz || e_a1s;
        e_a1f    = e_flush || (e_ds && !e_a1s);
        e_a2f    = e_flush || (e_alu_hz && hz.i_alu2_ready);
        e_inv    = (hist.size() >= INVD) && (hist[INVD-1] == 1'b0);
        e_busy   = 1'b0;
        for (int r = 0; r < 32; r++) if (sb[r]) e_busy = 1'b1;
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) sb[r] = 1'b0;
        hist.delete();
        flush_end = 0;
    endtask

    always @(negedge i_reset_n) model_reset();

    always @(posedge i_clk) begin
        if (!i_reset_n) begin
            model_reset();
        end else begin
            model_eval();
            if (hz.i_pc_change) flush_end = cyc + FLC;
            if (hz.i_lng_done) sb[hz.i_lng_done_rd] = 1'b0;
            if (hz.i_lng_issue && !e_ds && hz.i_lng_rd != 5'd0) sb[hz.i_lng_rd] = 1'b1;
            if (e_flush) begin
                hist.delete();
            end else if (!e_ds) begin
                hist.push_front(hz.i_decode_inst_sup);
                while (hist.size() > INVD) void'(hist.pop_back());
            end
        end
        cyc++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge i_clk) begin
        if (chk_en) begin
            model_eval();
            chk("cmp_fetch_stall",  hz.o_fetch_stall,  e_ds);
            chk("cmp_decode_stall", hz.o_decode_stall, e_ds);
            chk("cmp_decode_flush", hz.o_decode_flush, e_flush);
            chk("cmp_alu1_stall",   hz.o_alu1_stall,   e_a1s);
            chk("cmp_alu1_flush",   hz.o_alu1_flush,   e_a1f);
            chk("cmp_alu2_flush",   hz.o_alu2_flush,   e_a2f);
            chk("cmp_rs1_sel",      hz.o_rs1_sel,      e_sel1);
            chk("cmp_rs2_sel",      hz.o_rs2_sel,      e_sel2);
            chk("cmp_inv_inst",     hz.o_inv_inst,     e_inv);
            chk("cmp_sb_busy",      hz.o_sb_busy,      e_busy);
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        hz.i_pc_change       = 1'b0;
        hz.i_need_pause      = 1'b0;
        hz.i_alu2_ready      = 1'b1;
        hz.i_decode_inst_sup = 1'b1;
        hz.i_decode_rs1      = 5'd0;
        hz.i_decode_rs2      = 5'd0;
        hz.i_alu_rs1         = 5'd0;
        hz.i_alu_rs2         = 5'd0;
        hz.i_bp_rd           = '0;
        hz.i_bp_we           = '0;
        hz.i_bp_rdy          = '1;
        hz.i_lng_issue       = 1'b0;
        hz.i_lng_rd          = 5'd0;
        hz.i_lng_done        = 1'b0;
        hz.i_lng_done_rd     = 5'd0;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic mid();
        @(negedge i_clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        i_reset_n = 1'b0;
        idle();
        chk_en = 1'b1;

        // Reset state
        tick(); tick(); mid();
        chk("rst_decode_flush", hz.o_decode_flush, 1);
        chk("rst_fetch_stall",  hz.o_fetch_stall,  1);
        chk("rst_alu2_flush",   hz.o_alu2_flush,   1);
        chk("rst_alu1_stall",   hz.o_alu1_stall,   0);
        chk("rst_rs1_sel",      hz.o_rs1_sel,      0);
        chk("rst_inv_inst",     hz.o_inv_inst,     0);
        chk("rst_sb_busy",      hz.o_sb_busy,      0);
        tick(); i_reset_n = 1'b1; mid();
        chk("post_rst_flush", hz.o_decode_flush, 0);

        // 1: forwarding priority, x0 never forwarded
        tick(); hz.i_alu_rs1 = 5'd5; hz.i_bp_rd = {5'd5, 5'd0, 5'd5}; hz.i_bp_we = 3'b101; hz.i_bp_rdy = 3'b111; mid();
        chk("t1_rs1_sel_k0", hz.o_rs1_sel, 1);
        chk("t1_no_stall",   hz.o_decode_stall, 0);
        tick(); hz.i_bp_rd = {5'd5, 5'd0, 5'd0}; mid();
        chk("t1_rs1_sel_k2", hz.o_rs1_sel, 3);
        tick(); hz.i_alu_rs1 = 5'd0; hz.i_bp_rd = '0; hz.i_bp_we = 3'b111; mid();
        chk("t1_x0_sel", hz.o_rs1_sel, 0);

        // 2: forwarded value not ready, older ready copy ignored
        tick(); idle(); hz.i_alu_rs2 = 5'd7; hz.i_bp_rd = {5'd0, 5'd7, 5'd7}; hz.i_bp_we = 3'b011; hz.i_bp_rdy = 3'b110; mid();
        chk("t2_rs2_sel",      hz.o_rs2_sel,      1);
        chk("t2_alu1_stall",   hz.o_alu1_stall,   1);
        chk("t2_alu2_flush",   hz.o_alu2_flush,   1);
        chk("t2_decode_stall", hz.o_decode_stall, 1);
        chk("t2_alu1_flush",   hz.o_alu1_flush,   0);
        tick(); hz.i_bp_rdy = 3'b111; mid();
        chk("t2_clr_alu1_stall",   hz.o_alu1_stall,   0);
        chk("t2_clr_alu2_flush",   hz.o_alu2_flush,   0);
        chk("t2_clr_decode_stall", hz.o_decode_stall, 0);
        tick(); idle(); hz.i_alu2_ready = 1'b0; mid();
        chk("t2_bp_alu1_stall", hz.o_alu1_stall, 1);
        chk("t2_bp_alu2_flush", hz.o_alu2_flush, 0);

        // 3: scoreboard stall on rd=9, released one cycle after done
        tick(); idle(); hz.i_lng_issue = 1'b1; hz.i_lng_rd = 5'd9; mid();
        chk("t3_issue_no_stall", hz.o_decode_stall, 0);
        tick(); idle(); hz.i_decode_rs1 = 5'd9; mid();
        chk("t3_sb_busy",      hz.o_sb_busy,      1);
        chk("t3_decode_stall", hz.o_decode_stall, 1);
        chk("t3_alu1_flush",   hz.o_alu1_flush,   1);
        tick(); hz.i_lng_done = 1'b1; hz.i_lng_done_rd = 5'd9; mid();
        chk("t3_done_cycle_stall", hz.o_decode_stall, 1);
        tick(); hz.i_lng_done = 1'b0; mid();
        chk("t3_released", hz.o_decode_stall, 0);
        chk("t3_idle_busy", hz.o_sb_busy, 0);

        // 4: set wins over clear; x0 and stalled issues leave no entry
        tick(); idle(); hz.i_lng_issue = 1'b1; hz.i_lng_rd = 5'd4; hz.i_lng_done = 1'b1; hz.i_lng_done_rd = 5'd4;
        tick(); idle(); mid();
        chk("t4_set_wins", hz.o_sb_busy, 1);
        tick(); hz.i_lng_done = 1'b1; hz.i_lng_done_rd = 5'd4;
        tick(); idle(); mid();
        chk("t4_cleared", hz.o_sb_busy, 0);
        tick(); hz.i_lng_issue = 1'b1; hz.i_lng_rd = 5'd0;
        tick(); idle(); mid();
        chk("t4_x0_no_entry", hz.o_sb_busy, 0);
        tick(); hz.i_lng_issue = 1'b1; hz.i_lng_rd = 5'd12; hz.i_need_pause = 1'b1;
        tick(); idle(); mid();
        chk("t4_stalled_no_entry", hz.o_sb_busy, 0);

        // 5: multi-cycle redirect flush, scoreboard survives it
        tick(); hz.i_lng_issue = 1'b1; hz.i_lng_rd = 5'd3;
        tick(); idle(); hz.i_pc_change = 1'b1; mid();
        chk("t5_flush_c0", hz.o_decode_flush, 1);
        chk("t5_busy_c0",  hz.o_sb_busy, 1);
        tick(); idle(); mid();
        chk("t5_flush_c1", hz.o_decode_flush, 1);
        tick(); mid();
        chk("t5_flush_c2", hz.o_decode_flush, 1);
        tick(); mid();
        chk("t5_flush_c3", hz.o_decode_flush, 0);
        chk("t5_busy_after", hz.o_sb_busy, 1);
        tick(); hz.i_pc_change = 1'b1;
        tick(); hz.i_pc_change = 1'b1;
        tick(); idle(); mid();
        chk("t5_re_c2", hz.o_decode_flush, 1);
        tick(); mid();
        chk("t5_re_c3", hz.o_decode_flush, 1);
        tick(); mid();
        chk("t5_re_c4", hz.o_decode_flush, 0);
        tick(); hz.i_lng_done = 1'b1; hz.i_lng_done_rd = 5'd3;
        tick(); idle();

        // 6: invalid-instruction flag, hold under stall, async reset mid-operation
        tick(); hz.i_decode_inst_sup = 1'b0; mid();
        chk("t6_inv_a", hz.o_inv_inst, 0);
        tick(); hz.i_decode_inst_sup = 1'b1; mid();
        chk("t6_inv_b", hz.o_inv_inst, 0);
        tick(); mid();
        chk("t6_inv_c", hz.o_inv_inst, 1);
        tick(); mid();
        chk("t6_inv_d", hz.o_inv_inst, 0);
        tick(); hz.i_decode_inst_sup = 1'b0;
        tick(); hz.i_decode_inst_sup = 1'b1;
        tick(); hz.i_need_pause = 1'b1; mid();
        chk("t6_hold_0", hz.o_inv_inst, 1);
        tick(); mid();
        chk("t6_hold_1", hz.o_inv_inst, 1);
        tick(); idle(); mid();
        chk("t6_hold_2", hz.o_inv_inst, 1);
        tick(); mid();
        chk("t6_hold_done", hz.o_inv_inst, 0);
        tick(); hz.i_decode_inst_sup = 1'b0;
        tick(); hz.i_decode_inst_sup = 1'b1;
        tick(); idle(); mid();
        chk("t6_pre_rst", hz.o_inv_inst, 1);
        #2 i_reset_n = 1'b0;
        #1;
        chk("t6_rst_inv",   hz.o_inv_inst, 0);
        chk("t6_rst_flush", hz.o_decode_flush, 1);
        tick(); tick(); i_reset_n = 1'b1; mid();
        chk("t6_after_rst_inv", hz.o_inv_inst, 0);

        tick(); mid();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
